change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream stage of the candy vending FSM; consumes its change request (amount over 30 cents) and physically pays it out.
- Greedy selection, one coin per clock: 25c first, then 10c, then 5c.
- Tracks per-denomination coin inventory; reports any unpaid remainder as shortfall.
- Coin encoding on the output matches the vending FSM's coin input: 01=5c, 10=10c, 11=25c, 00=none.

Parameters:
- CHANGE_W, 6, width of change amount and shortfall (cents, max 63)
- INV_W, 4, width of each inventory counter
- INV_INIT, 8, per-denomination count loaded on reset and on refill (must fit INV_W)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  change request present
- req_amount  in  CHANGE_W  change owed, cents
- req_ready  out  1  high only in IDLE
- refill  in  1  single-cycle pulse; reload all inventories to INV_INIT
- coin_in  in  2  inserted-coin code (used only with COIN_RECYCLE_EN)
- coin_strobe  out  1  one-cycle pulse per dispensed coin
- coin_out  out  2  denomination of the dispensed coin; 00 when coin_strobe low
- done  out  1  one-cycle pulse at end of a request
- shortfall  out  CHANGE_W  unpaid cents; valid with done, held until next accept
- inv25, inv10, inv5  out  INV_W each  current inventories

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, rem=0.
  - coin_strobe=0, coin_out=00, done=0, shortfall=0.
  - inv25=inv10=inv5=INV_INIT.
  - req_ready=1 once rst deasserts.
- States: IDLE, DISPENSE, DONE.
- IDLE:
  - Accept when req_valid && req_ready.
  - rem <= req_amount; shortfall <= 0; go to DISPENSE.
  - req_amount=0 is still accepted; DISPENSE sees rem=0 and goes straight to DONE (no coins).
- DISPENSE: exactly one action per cycle, in priority order:
  - rem>=25 && inv25>0: strobe, coin_out=11, rem-=25, inv25-=1.
  - else rem>=10 && inv10>0: strobe, coin_out=10, rem-=10, inv10-=1.
  - else rem>=5 && inv5>0: strobe, coin_out=01, rem-=5, inv5-=1.
  - else no coin: shortfall <= rem, go to DONE.
  - rem never underflows; amounts not a multiple of 5 leave the residue (1-4) as shortfall.
- DONE: done=1 for one cycle, then IDLE.
- Latency:
  - Accept at cycle N; first coin strobe at N+1.
  - done asserts 2 cycles after the last coin: one cycle for DISPENSE to find nothing left, then one cycle in DONE.
  - For amount=0: done at N+2.
- Inputs while busy:
  - req_valid outside IDLE is ignored; no queueing.
  - Upstream must hold req_valid until it sees req_ready.
- Refill:
  - refill=1 loads all three inventories to INV_INIT that cycle.
  - Refill takes precedence over a same-cycle decrement; the coin is still strobed.
  - Allowed in any state; an in-progress DISPENSE continues using the new counts.
- Counter rules: decrement only when >0; increments saturate at 2^INV_W-1.
- Reset mid-dispense: immediate return to IDLE, inventories restored, no done pulse.

Optional Feature:
- Macro: COIN_RECYCLE_EN.
- Defined:
  - Each cycle, a coin_in of 01/10/11 increments inv5/inv10/inv25 respectively (saturating).
  - Same-cycle increment and dispense decrement on one denomination leaves the count unchanged.
  - Refill overrides both.
- Undefined: coin_in is ignored; inventories change only via dispense, refill and reset.

Test Plan:
- Reset, amount=40, full inventory -> coins 11 then 10 then 01 on consecutive cycles; done with shortfall=0; inv25=7, inv10=7, inv5=7.
- Amount=0 -> no coin_strobe; done exactly 2 cycles after accept; shortfall=0.
- INV_INIT=8, drain inv25 to 0 via refill-free requests of 25, then amount=25 -> two 10c coins + one 5c coin; shortfall=0.
- Inventories 0/0/1 (25/10/5), amount=23 -> one 01 coin; done with shortfall=18.
- Assert rst during the 2nd coin of amount=50 -> outputs cleared immediately; inventories=INV_INIT; no done; next request served normally.
- COIN_RECYCLE_EN: coin_in=11 on the same cycle a 25c is dispensed -> inv25 unchanged; coin_in=11 while inv25=15 (INV_W=4) -> stays 15; undefined build -> coin_in has no effect.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Handshake and status bundle between the vending FSM (master) and the change
// dispenser (slave).
//   req_valid/req_amount/req_ready : change request handshake
//   refill                         : reload all coin inventories
//   coin_in                        : inserted-coin code (01=5c, 10=10c, 11=25c)
//   coin_strobe/coin_out           : one dispensed coin per strobe
//   done/shortfall                 : end of request and unpaid cents
//   inv25/inv10/inv5               : current coin inventories
interface change_dispenser_if #(
  parameter int unsigned CHANGE_W = 6,
  parameter int unsigned INV_W    = 4
);
  logic                req_valid;
  logic [CHANGE_W-1:0] req_amount;
  logic                req_ready;
  logic                refill;
  logic [1:0]          coin_in;
  logic                coin_strobe;
  logic [1:0]          coin_out;
  logic                done;
  logic [CHANGE_W-1:0] shortfall;
  logic [INV_W-1:0]    inv25;
  logic [INV_W-1:0]    inv10;
  logic [INV_W-1:0]    inv5;

  modport master (
    output req_valid, req_amount, refill, coin_in,
    input  req_ready, coin_strobe, coin_out, done, shortfall, inv25, inv10, inv5
  );

  modport slave (
    input  req_valid, req_amount, refill, coin_in,
    output req_ready, coin_strobe, coin_out, done, shortfall, inv25, inv10, inv5
  );
endinterface

// File: rtl/change_dispenser.sv
// Change dispenser: accepts a change amount, pays it out greedily one coin per
// clock (25c, then 10c, then 5c) from per-denomination inventories and reports
// any unpaid remainder as shortfall.
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : change_dispenser_if.slave (request handshake, refill, coin_in,
//          coin strobe/code, done/shortfall, inventories)
// Optional macro COIN_RECYCLE_EN: inserted coins on coin_in top up the
// matching inventory (saturating). Without it coin_in is ignored.
module change_dispenser #(
  parameter int unsigned CHANGE_W = 6,
  parameter int unsigned INV_W    = 4,
  parameter int unsigned INV_INIT = 8
) (
  input logic              clk,
  input logic              rst,
  change_dispenser_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StDispense, StDone} state_e;

  localparam logic [INV_W-1:0]    InvInit = INV_W'(INV_INIT);
  localparam logic [INV_W-1:0]    InvMax  = '1;
  localparam logic [CHANGE_W-1:0] Cents25 = CHANGE_W'(25);
  localparam logic [CHANGE_W-1:0] Cents10 = CHANGE_W'(10);
  localparam logic [CHANGE_W-1:0] Cents5  = CHANGE_W'(5);

  state_e              state_q;
  logic [CHANGE_W-1:0] rem_q;
  logic                coin_strobe_q;
  logic [1:0]          coin_out_q;
  logic                done_q;
  logic [CHANGE_W-1:0] shortfall_q;
  logic [INV_W-1:0]    inv25_q, inv10_q, inv5_q;
  logic [INV_W-1:0]    inv25_d, inv10_d, inv5_d;

  logic take25, take10, take5;
  logic inc25, inc10, inc5;

  // Saturating increment, decrement only when non-zero; both at once cancel.
  function automatic logic [INV_W-1:0] inv_next(input logic [INV_W-1:0] cur,
                                                input logic inc, input logic dec);
    logic [INV_W-1:0] nxt;
    nxt = cur;
    if (inc && !dec && cur != InvMax) nxt = cur + INV_W'(1);
    if (dec && !inc && cur != '0)     nxt = cur - INV_W'(1);
    return nxt;
  endfunction

  always_comb begin
    take25 = 1'b0;
    take10 = 1'b0;
    take5  = 1'b0;
    if (state_q == StDispense) begin
      if (rem_q >= Cents25 && inv25_q != '0)     take25 = 1'b1;
      else if (rem_q >= Cents10 && inv10_q != '0) take10 = 1'b1;
      else if (rem_q >= Cents5 && inv5_q != '0)   take5  = 1'b1;
    end
  end

`ifdef COIN_RECYCLE_EN
  always_comb begin
    inc25 = (bus.coin_in == 2'b11);
    inc10 = (bus.coin_in == 2'b10);
    inc5  = (bus.coin_in == 2'b01);
  end
`else
  logic unused_coin_in;
  assign unused_coin_in = ^bus.coin_in;
  always_comb begin
    inc25 = 1'b0;
    inc10 = 1'b0;
    inc5  = 1'b0;
  end
`endif

  always_comb begin
    inv25_d = inv_next(inv25_q, inc25, take25);
    inv10_d = inv_next(inv10_q, inc10, take10);
    inv5_d  = inv_next(inv5_q,  inc5,  take5);
    // Refill wins over both dispense and recycle updates.
    if (bus.refill) begin
      inv25_d = InvInit;
      inv10_d = InvInit;
      inv5_d  = InvInit;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      rem_q         <= '0;
      coin_strobe_q <= 1'b0;
      coin_out_q    <= 2'b00;
      done_q        <= 1'b0;
      shortfall_q   <= '0;
      inv25_q       <= InvInit;
      inv10_q       <= InvInit;
      inv5_q        <= InvInit;
    end else begin
      coin_strobe_q <= 1'b0;
      coin_out_q    <= 2'b00;
      done_q        <= 1'b0;
      inv25_q       <= inv25_d;
      inv10_q       <= inv10_d;
      inv5_q        <= inv5_d;
      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            rem_q       <= bus.req_amount;
            shortfall_q <= '0;
            state_q     <= StDispense;
          end
        end
        StDispense: begin
          if (take25) begin
            coin_strobe_q <= 1'b1;
            coin_out_q    <= 2'b11;
            rem_q         <= rem_q - Cents25;
          end else if (take10) begin
            coin_strobe_q <= 1'b1;
            coin_out_q    <= 2'b10;
            rem_q         <= rem_q - Cents10;
          end else if (take5) begin
            coin_strobe_q <= 1'b1;
            coin_out_q    <= 2'b01;
            rem_q         <= rem_q - Cents5;
          end else begin
            shortfall_q <= rem_q;
            state_q     <= StDone;
          end
        end
        StDone: begin
          // done appears as the FSM returns to idle, two cycles after the last coin.
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready   = (state_q == StIdle);
  assign bus.coin_strobe = coin_strobe_q;
  assign bus.coin_out    = coin_out_q;
  assign bus.done        = done_q;
  assign bus.shortfall   = shortfall_q;
  assign bus.inv25       = inv25_q;
  assign bus.inv10       = inv10_q;
  assign bus.inv5        = inv5_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser.
module tb_change_dispenser;

  logic clk;
  logic rst;

  change_dispenser_if #(.CHANGE_W(6), .INV_W(4)) bus ();

  change_dispenser #(.CHANGE_W(6), .INV_W(4), .INV_INIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] coins[$];
  int         done_at;
  logic       saw_done;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request and collect coins until done (bounded).
  task automatic do_req(input logic [5:0] amt);
    coins = {};
    done_at = -1;
    check("ready_before_req", int'(bus.req_ready), 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = amt;
    step();
    bus.req_valid  = 1'b0;
    for (int i = 1; i <= 30 && done_at < 0; i++) begin
      step();
      if (bus.coin_strobe) coins.push_back(bus.coin_out);
      if (bus.done) done_at = i;
    end
    if (done_at < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    bus.refill     = 1'b0;
    bus.coin_in    = 2'b00;
    step();
    step();
    check("rst_strobe", int'(bus.coin_strobe), 0);
    check("rst_coin_out", int'(bus.coin_out), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_shortfall", int'(bus.shortfall), 0);
    check("rst_inv25", int'(bus.inv25), 8);
    check("rst_inv10", int'(bus.inv10), 8);
    check("rst_inv5", int'(bus.inv5), 8);
    rst = 1'b0;
    #1;
    check("rst_ready", int'(bus.req_ready), 1);

    // 40c, full inventory: 25, 10, 5 then done two cycles after last coin.
    do_req(6'd40);
    check("a40_ncoins", coins.size(), 3);
    check("a40_coin0", int'(coins[0]), 3);
    check("a40_coin1", int'(coins[1]), 2);
    check("a40_coin2", int'(coins[2]), 1);
    check("a40_done_at", done_at, 5);
    check("a40_shortfall", int'(bus.shortfall), 0);
    check("a40_coin_out_idle", int'(bus.coin_out), 0);
    check("a40_inv25", int'(bus.inv25), 7);
    check("a40_inv10", int'(bus.inv10), 7);
    check("a40_inv5", int'(bus.inv5), 7);
    step();
    check("a40_done_pulse", int'(bus.done), 0);
    check("a40_shortfall_hold", int'(bus.shortfall), 0);

    // 0c: no coins, done two cycles after accept.
    do_req(6'd0);
    check("a0_ncoins", coins.size(), 0);
    check("a0_done_at", done_at, 2);
    check("a0_shortfall", int'(bus.shortfall), 0);

    // Drain inv25 (7 left), then 25c falls back to 10+10+5.
    for (int k = 0; k < 7; k++) do_req(6'd25);
    check("drain_inv25", int'(bus.inv25), 0);
    do_req(6'd25);
    check("f25_ncoins", coins.size(), 3);
    check("f25_coin0", int'(coins[0]), 2);
    check("f25_coin1", int'(coins[1]), 2);
    check("f25_coin2", int'(coins[2]), 1);
    check("f25_shortfall", int'(bus.shortfall), 0);
    check("f25_inv10", int'(bus.inv10), 5);
    check("f25_inv5", int'(bus.inv5), 6);

    // Bring inventories to 0/0/1.
    do_req(6'd50);
    check("drain_inv10", int'(bus.inv10), 0);
    do_req(6'd25);
    check("drain_inv5", int'(bus.inv5), 1);

    // 23c with 0/0/1: one 5c, shortfall 18.
    do_req(6'd23);
    check("a23_ncoins", coins.size(), 1);
    check("a23_coin0", int'(coins[0]), 1);
    check("a23_shortfall", int'(bus.shortfall), 18);
    check("a23_done_at", done_at, 3);
    check("a23_inv5", int'(bus.inv5), 0);

    // Refill pulse reloads everything.
    bus.refill = 1'b1;
    step();
    bus.refill = 1'b0;
    check("refill_inv25", int'(bus.inv25), 8);
    check("refill_inv10", int'(bus.inv10), 8);
    check("refill_inv5", int'(bus.inv5), 8);

    // Refill on the same cycle as a 25c decrement: coin still strobed, count 8.
    bus.req_valid  = 1'b1;
    bus.req_amount = 6'd25;
    step();
    bus.req_valid = 1'b0;
    bus.refill    = 1'b1;
    step();
    bus.refill = 1'b0;
    check("refprec_strobe", int'(bus.coin_strobe), 1);
    check("refprec_coin", int'(bus.coin_out), 3);
    check("refprec_inv25", int'(bus.inv25), 8);
    step();
    step();
    check("refprec_done", int'(bus.done), 1);

    // Reset during the 2nd coin of 50c.
    bus.req_valid  = 1'b1;
    bus.req_amount = 6'd50;
    step();
    bus.req_valid = 1'b0;
    step();
    check("r50_coin1", int'(bus.coin_out), 3);
    step();
    check("r50_coin2_strobe", int'(bus.coin_strobe), 1);
    check("r50_inv25_mid", int'(bus.inv25), 6);
    rst = 1'b1;
    #1;
    check("r50_rst_strobe", int'(bus.coin_strobe), 0);
    check("r50_rst_coin_out", int'(bus.coin_out), 0);
    check("r50_rst_ready", int'(bus.req_ready), 1);
    check("r50_rst_inv25", int'(bus.inv25), 8);
    step();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.done || bus.coin_strobe) saw_done = 1'b1;
    end
    check("r50_no_done", int'(saw_done), 0);
    do_req(6'd40);
    check("post_rst_ncoins", coins.size(), 3);
    check("post_rst_done_at", done_at, 5);
    check("post_rst_inv25", int'(bus.inv25), 7);

`ifdef COIN_RECYCLE_EN
    // Inserted 25c on the same cycle a 25c goes out: inv25 stays 7.
    bus.req_valid  = 1'b1;
    bus.req_amount = 6'd25;
    step();
    bus.req_valid = 1'b0;
    bus.coin_in   = 2'b11;
    step();
    bus.coin_in = 2'b00;
    check("rec_coin", int'(bus.coin_out), 3);
    check("rec_cancel_inv25", int'(bus.inv25), 7);
    step();
    step();
    check("rec_done", int'(bus.done), 1);
    // Saturate inv25 at 15 (needs 8 inserts from 7; the 9th must not wrap).
    bus.coin_in = 2'b11;
    for (int i = 0; i < 9; i++) step();
    bus.coin_in = 2'b00;
    check("rec_sat_inv25", int'(bus.inv25), 15);
    bus.coin_in = 2'b01;
    step();
    bus.coin_in = 2'b00;
    check("rec_inc_inv5", int'(bus.inv5), 8);
`else
    // coin_in must not touch inventories.
    bus.coin_in = 2'b11;
    step();
    bus.coin_in = 2'b10;
    step();
    bus.coin_in = 2'b01;
    step();
    bus.coin_in = 2'b00;
    check("norec_inv25", int'(bus.inv25), 7);
    check("norec_inv10", int'(bus.inv10), 7);
    check("norec_inv5", int'(bus.inv5), 7);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
